dcache: RTL and testbench
=========================

# dcache

Direct-mapped, write-back, write-allocate data cache between the pipeline's MEM stage and unified main memory. Serves MEM-stage loads and stores in zero added cycles on a hit. On a miss it stalls the pipeline while it writes back any dirty victim line and fetches the new line. At halt it flushes all dirty lines so memory is coherent for the testbench dump.

## Interface
- INDEX_W, 3: index bits; the cache holds 2^INDEX_W lines of 4 × 16-bit words.
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cpu_addr  in  16  word address from the MEM stage (ALU result).
- cpu_rd  in  1  load request.
- cpu_wr  in  1  store request; takes priority if asserted together with cpu_rd.
- cpu_wrData  in  16  store data.
- cpu_rdData  out  16  load data; valid when cpu_rd=1 and cpu_stall=0.
- cpu_stall  out  1  pipeline must freeze and hold its request stable.
- flush  in  1  level; writes back all dirty lines (driven from halt).
- flush_done  out  1  high once the flush completes; stays high until flush drops.
- mem_addr  out  14  line address (cpu_addr[15:2]).
- mem_rd  out  1  line read request.
- mem_wr  out  1  line write request.
- mem_wrData  out  64  victim line; word 0 is in [15:0].
- mem_rdData  in  64  fill line, same packing as mem_wrData.
- mem_rdy  in  1  memory accepted or completed the current request.

## Operation
- Address split: tag = addr[15:2+INDEX_W], index = addr[1+INDEX_W:2], offset = addr[1:0].
- Per-line state: valid, dirty, tag, and 4 data words.
- Hit = request && valid[index] && tag match.
- FSM states: IDLE, WB, ALLOC, FL_SCAN, FL_WB, FL_DONE.
- **IDLE, read hit:** cpu_rdData = selected word, combinationally, with cpu_stall=0.
- **IDLE, write hit:** the word is written and dirty is set at the clock edge.
- **IDLE, miss:** cpu_stall=1 in the same cycle. Go to WB if the victim is valid && dirty, otherwise to ALLOC.
- **WB:** mem_wr=1 with mem_addr = {victim tag, index} and mem_wrData = victim line. On mem_rdy go to ALLOC.
- **ALLOC:** mem_rd=1 with mem_addr = cpu_addr[15:2]. On mem_rdy, write the line from mem_rdData and set valid=1, dirty=0, tag. Go to IDLE. The held request then hits and stall drops.
- Once a miss is taken, the WB/ALLOC sequence always completes, even if cpu_rd/cpu_wr drop.
- **IDLE with flush=1 and no pending miss:** go to FL_SCAN with the scan index at 0.
  - FL_SCAN: a dirty line goes to FL_WB; otherwise increment the index.
  - FL_WB: mem_wr until mem_rdy, then clear that line's dirty bit and return to FL_SCAN.
  - After the last index is checked, go to FL_DONE.
  - cpu_stall=1 throughout FL_*.
- **FL_DONE:** flush_done=1. Return to IDLE when flush=0.
- mem_rd and mem_wr are never high together. Address and data stay stable while a request is pending.

## Timing
- Reset values: every valid and dirty bit 0, state IDLE, mem_rd=0, mem_wr=0, flush_done=0, cpu_stall=0, cpu_rdData=0. Tags and data are don't-care.
- Hit latency: 0 cycles added (combinational read, store written at the edge).
- Clean miss penalty: 1 + L_rd cycles, where L_rd = cycles from mem_rd rising to mem_rdy inclusive.
- Dirty miss penalty: 1 + L_wr + L_rd.
- mem_rdy is sampled only while a request is high. mem_rdy seen in the same cycle a request rises counts as completion.
- Flush with D dirty lines: 2^INDEX_W + D × (L_wr + 1) cycles, approximately.
- Reset asserted mid-transaction:
  - The request is abandoned immediately and mem_rd/mem_wr drop asynchronously.
  - All lines are invalidated and dirty data is lost by design.
- Scan index wrap: the index is INDEX_W+1 bits wide, and its MSB set means the scan is done.

## Structure
- Shared package dcache_pkg holds:
  - the state enum;
  - the OFFSET_W=2 and WORDS=4 constants;
  - tag/index width functions of INDEX_W;
  - the 64-bit line type.
- Sub-module dcache_array holds tag/valid/dirty/data storage with asynchronous read and synchronous write. It provides a word-write port, a full-line fill port, and a dirty-clear port. Valid and dirty reset asynchronously.
- The dcache top contains the FSM, address split, hit logic, and the memory request muxing.

## Test plan
- **Cold load miss then hit.** Load 0x0010 with mem_rdy after 3 cycles and mem_rdData=0x4444_3333_2222_1111. Expect mem_rd with mem_addr=0x0004, stall for 4 cycles, then cpu_rdData=0x1111. A load of 0x0013 next cycle gives 0x4444 with no stall.
- **Write hit sets dirty.** After the fill, store 0xBEEF to 0x0011, then load 0x0011. Expect 0xBEEF with no stall and no mem traffic.
- **Dirty eviction.** Load 0x0030 (same index as 0x0010, INDEX_W=3). Expect mem_wr first with mem_addr=0x0004 and mem_wrData=0x4444_3333_BEEF_1111, then mem_rd with mem_addr=0x000C.
- **Flush.** With 2 lines dirty, assert flush. Expect exactly 2 mem_wr transactions, then flush_done=1; a second flush produces 0 writes.
- **Reset mid-ALLOC.** Pull rst_n low while mem_rd=1. Expect mem_rd=0 and cpu_stall=0 immediately; after release, a load of the previous address misses again.
- **Simultaneous cpu_rd and cpu_wr.** Assert both on a hit to 0x0012 with data 0x00AA. Expect the store to be performed (word = 0x00AA, dirty=1).

Source files
------------

// File: rtl/dcache_pkg.sv
// dcache_pkg: definitions shared by the data cache top and its storage array.
//   - state_t      : cache controller FSM states
//   - OFFSET_W     : word-offset bits inside a line (4 words per line)
//   - WORDS        : words per line
//   - line_t       : one 64-bit cache line, word 0 in bits [15:0]
//   - tag_width()  : tag bits for a given index width
//   - scan_width() : flush scan counter width (one extra bit marks "done")
package dcache_pkg;
  localparam int ADDR_W   = 16;
  localparam int WORD_W   = 16;
  localparam int OFFSET_W = 2;
  localparam int WORDS    = 4;

  typedef logic [WORDS*WORD_W-1:0] line_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WB      = 3'd1,
    ALLOC   = 3'd2,
    FL_SCAN = 3'd3,
    FL_WB   = 3'd4,
    FL_DONE = 3'd5
  } state_t;

  function automatic int tag_width(input int index_w);
    return ADDR_W - OFFSET_W - index_w;
  endfunction

  function automatic int scan_width(input int index_w);
    return index_w + 1;
  endfunction
endpackage

// File: rtl/dcache_array.sv
// dcache_array: tag/valid/dirty/data storage for the direct-mapped cache.
// All ports address the same line through idx; reads are asynchronous.
//   idx                 : line being read and written this cycle
//   valid/dirty/tag/line: read data of line idx
//   word_we/off/data    : store one 16-bit word into line idx, mark dirty
//   fill_we/tag/line    : replace line idx, mark valid and clean
//   clr_we              : clear dirty of line idx (after a flush write-back)
// Valid and dirty reset asynchronously; tags and data are not reset.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int INDEX_W = 3,
  parameter int TAG_W   = tag_width(INDEX_W)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [INDEX_W-1:0]  idx,
  output logic                valid,
  output logic                dirty,
  output logic [TAG_W-1:0]    tag,
  output line_t               line,
  input  logic                word_we,
  input  logic [OFFSET_W-1:0] word_off,
  input  logic [WORD_W-1:0]   word_data,
  input  logic                fill_we,
  input  logic [TAG_W-1:0]    fill_tag,
  input  line_t               fill_line,
  input  logic                clr_we
);
  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0] valid_r;
  logic [LINES-1:0] dirty_r;
  logic [TAG_W-1:0] tag_r  [LINES];
  line_t            data_r [LINES];

  assign valid = valid_r[idx];
  assign dirty = dirty_r[idx];
  assign tag   = tag_r[idx];
  assign line  = data_r[idx];

  // Line status bits; a fill always leaves the line clean
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= '0;
      dirty_r <= '0;
    end else if (fill_we) begin
      valid_r[idx] <= 1'b1;
      dirty_r[idx] <= 1'b0;
    end else if (word_we) begin
      dirty_r[idx] <= 1'b1;
    end else if (clr_we) begin
      dirty_r[idx] <= 1'b0;
    end
  end

  // Tag and data storage, no reset needed because valid gates their use
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_r[idx]  <= fill_tag;
      data_r[idx] <= fill_line;
    end else if (word_we) begin
      data_r[idx][{word_off, 4'h0} +: WORD_W] <= word_data;
    end
  end
endmodule

// File: rtl/dcache.sv
// dcache: direct-mapped, write-back, write-allocate data cache.
//   cpu_addr/cpu_rd/cpu_wr/cpu_wrData : MEM-stage request (store wins over load)
//   cpu_rdData                        : load data, combinational on a hit
//   cpu_stall                         : freeze pipeline during miss or flush
//   flush / flush_done                : write back all dirty lines, then report
//   mem_addr/mem_rd/mem_wr/mem_wrData : line request to main memory
//   mem_rdData/mem_rdy                : fill line and request completion
module dcache
  import dcache_pkg::*;
#(
  parameter int INDEX_W = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [15:0] cpu_wrData,
  output logic [15:0] cpu_rdData,
  output logic        cpu_stall,
  input  logic        flush,
  output logic        flush_done,
  output logic [13:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output line_t       mem_wrData,
  input  line_t       mem_rdData,
  input  logic        mem_rdy
);
  localparam int TAG_W  = tag_width(INDEX_W);
  localparam int SCAN_W = scan_width(INDEX_W);

  state_t              state_r, state_s;
  logic [SCAN_W-1:0]   scan_r;
  logic [13:0]         miss_line_r;
  logic [TAG_W-1:0]    cpu_tag_s, line_tag_s;
  logic [INDEX_W-1:0]  cpu_idx_s, miss_idx_s, arr_idx_s;
  logic [OFFSET_W-1:0] cpu_off_s;
  logic                line_valid_s, line_dirty_s;
  line_t               line_data_s;
  logic                req_s, hit_s, miss_s, stall_s;
  logic                word_we_s, fill_we_s, clr_we_s;

  assign cpu_tag_s  = cpu_addr[15 -: TAG_W];
  assign cpu_idx_s  = cpu_addr[OFFSET_W +: INDEX_W];
  assign cpu_off_s  = cpu_addr[OFFSET_W-1:0];
  assign miss_idx_s = miss_line_r[INDEX_W-1:0];
  assign req_s      = cpu_rd | cpu_wr;
  assign hit_s      = req_s & line_valid_s & (line_tag_s == cpu_tag_s);
  assign miss_s     = (state_r == IDLE) & req_s & ~hit_s;
  assign mem_wrData = line_data_s;
  // Stall is forced low while reset is held so the pipeline is released at once
  assign cpu_stall  = stall_s & rst_n;

  // Array index: CPU address when idle, latched miss line during WB/ALLOC, scan index in flush
  always_comb begin
    case (state_r)
      WB, ALLOC:      arr_idx_s = miss_idx_s;
      FL_SCAN, FL_WB: arr_idx_s = scan_r[INDEX_W-1:0];
      default:        arr_idx_s = cpu_idx_s;
    endcase
  end

  dcache_array #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_array (
    .clk       (clk),
    .rst_n     (rst_n),
    .idx       (arr_idx_s),
    .valid     (line_valid_s),
    .dirty     (line_dirty_s),
    .tag       (line_tag_s),
    .line      (line_data_s),
    .word_we   (word_we_s),
    .word_off  (cpu_off_s),
    .word_data (cpu_wrData),
    .fill_we   (fill_we_s),
    .fill_tag  (miss_line_r[13 -: TAG_W]),
    .fill_line (mem_rdData),
    .clr_we    (clr_we_s)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Miss line latch and flush scan index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_r      <= '0;
      miss_line_r <= '0;
    end else begin
      // Latching the line keeps WB/ALLOC going even if the request drops
      if (miss_s) begin
        miss_line_r <= cpu_addr[15:2];
      end
      if (state_r == IDLE) begin
        scan_r <= '0;
      end else if ((state_r == FL_SCAN) && !scan_r[INDEX_W] && !line_dirty_s) begin
        scan_r <= scan_r + SCAN_W'(1);
      end
    end
  end

  // FSM next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (miss_s) begin
          state_s = (line_valid_s && line_dirty_s) ? WB : ALLOC;
        end else if (flush) begin
          state_s = FL_SCAN;
        end else begin
          state_s = IDLE;
        end
      end
      WB:      state_s = mem_rdy ? ALLOC : WB;
      ALLOC:   state_s = mem_rdy ? IDLE : ALLOC;
      FL_SCAN: begin
        // The scan index MSB marks that every line has been visited;
        // a dirty line is rescanned after its write-back clears it
        if (scan_r[INDEX_W]) begin
          state_s = FL_DONE;
        end else if (line_dirty_s) begin
          state_s = FL_WB;
        end else begin
          state_s = FL_SCAN;
        end
      end
      FL_WB:   state_s = mem_rdy ? FL_SCAN : FL_WB;
      FL_DONE: state_s = flush ? FL_DONE : IDLE;
      default: state_s = IDLE;
    endcase
  end

  // FSM outputs: memory requests, stall, array write strobes, load data
  always_comb begin
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = cpu_addr[15:2];
    stall_s    = 1'b0;
    flush_done = 1'b0;
    word_we_s  = 1'b0;
    fill_we_s  = 1'b0;
    clr_we_s   = 1'b0;
    cpu_rdData = 16'h0000;
    case (state_r)
      IDLE: begin
        stall_s   = miss_s;
        word_we_s = cpu_wr & hit_s;
        if (cpu_rd && hit_s) begin
          cpu_rdData = line_data_s[{cpu_off_s, 4'h0} +: 16];
        end else begin
          cpu_rdData = 16'h0000;
        end
      end
      WB: begin
        mem_wr   = 1'b1;
        mem_addr = {line_tag_s, miss_idx_s};
        stall_s  = 1'b1;
      end
      ALLOC: begin
        mem_rd    = 1'b1;
        mem_addr  = miss_line_r;
        stall_s   = 1'b1;
        fill_we_s = mem_rdy;
      end
      FL_SCAN: begin
        stall_s = 1'b1;
      end
      FL_WB: begin
        mem_wr   = 1'b1;
        mem_addr = {line_tag_s, scan_r[INDEX_W-1:0]};
        stall_s  = 1'b1;
        clr_we_s = mem_rdy;
      end
      FL_DONE: begin
        stall_s    = 1'b1;
        flush_done = 1'b1;
      end
      default: begin
        stall_s = 1'b0;
      end
    endcase
  end
endmodule

// File: tb/tb_dcache.sv
// tb_dcache: directed, self-checking bench for dcache (INDEX_W=3).
// A behavioural main memory answers line requests after a programmable
// latency and logs every transaction; single-cycle hits come from a table.
module tb_dcache;
  import dcache_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cpu_addr;
  logic        cpu_rd, cpu_wr;
  logic [15:0] cpu_wrData;
  logic [15:0] cpu_rdData;
  logic        cpu_stall;
  logic        flush, flush_done;
  logic [13:0] mem_addr;
  logic        mem_rd, mem_wr;
  line_t       mem_wrData, mem_rdData;
  logic        mem_rdy;

  dcache #(.INDEX_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_wrData(cpu_wrData), .cpu_rdData(cpu_rdData), .cpu_stall(cpu_stall),
    .flush(flush), .flush_done(flush_done), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .mem_wrData(mem_wrData), .mem_rdData(mem_rdData), .mem_rdy(mem_rdy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [13:0] addr;
    line_t       data;
  } txn_t;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
  } vec_t;

  txn_t  log_q[$];
  line_t mem_model [bit [13:0]];
  vec_t  tab [10];
  int    lat_rd = 3;
  int    lat_wr = 2;
  int    n_vec = 0;
  int    n_bad = 0;
  int    n;
  logic  stall_ok;
  logic  overlap_seen = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_txn(input string nm, input int i, input logic wr,
                         input logic [13:0] addr, input line_t data, input logic use_data);
    if (i >= log_q.size()) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: transaction %0d missing, got %0d transactions", nm, i, log_q.size());
    end else begin
      chk({nm, "_wr"}, 64'(log_q[i].wr), 64'(wr));
      chk({nm, "_addr"}, 64'(log_q[i].addr), 64'(addr));
      if (use_data) chk({nm, "_data"}, log_q[i].data, data);
    end
  endtask

  // Issue a request that misses; count stalled cycles until it completes
  task automatic do_miss(input logic rd, input logic wr, input logic [15:0] addr,
                         input logic [15:0] wd, input int exp_stall, input string nm);
    int k;
    @(posedge clk); #1;
    cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_wrData = wd;
    k = 0;
    @(negedge clk);
    while (cpu_stall && k < 100) begin
      k++;
      @(negedge clk);
    end
    chk({nm, "_stall_cycles"}, 64'(k), 64'(exp_stall));
  endtask

  // One hit per cycle: no stall, and load data where a pure load is issued
  task automatic apply_range(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      @(posedge clk); #1;
      cpu_rd = tab[i].rd; cpu_wr = tab[i].wr; cpu_addr = tab[i].addr; cpu_wrData = tab[i].wdata;
      @(negedge clk);
      chk($sformatf("vec%0d_stall", i), 64'(cpu_stall), 64'd0);
      if (tab[i].rd && !tab[i].wr) chk($sformatf("vec%0d_rdata", i), 64'(cpu_rdData), 64'(tab[i].exp_rdata));
    end
    @(posedge clk); #1;
    cpu_rd = 1'b0; cpu_wr = 1'b0;
  endtask

  // Main memory model: completes each request after lat_rd/lat_wr cycles
  initial begin : mem_resp
    int cnt;
    cnt = 0;
    mem_rdy = 1'b0;
    mem_rdData = '0;
    forever begin
      @(negedge clk);
      if (mem_rd && mem_wr) overlap_seen = 1'b1;
      if (mem_rd || mem_wr) begin
        if (cnt == 0) begin
          log_q.push_back('{wr: mem_wr, addr: mem_addr, data: mem_wrData});
          if (mem_wr) mem_model[mem_addr] = mem_wrData;
        end
        if (cnt >= (mem_wr ? lat_wr : lat_rd) - 1) begin
          mem_rdy = 1'b1;
          mem_rdData = mem_model.exists(mem_addr) ? mem_model[mem_addr] : '0;
          cnt = 0;
        end else begin
          mem_rdy = 1'b0;
          cnt++;
        end
      end else begin
        mem_rdy = 1'b0;
        cnt = 0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    tab[0] = '{1'b1, 1'b0, 16'h0013, 16'h0000, 16'h4444};
    tab[1] = '{1'b0, 1'b1, 16'h0011, 16'hBEEF, 16'h0000};
    tab[2] = '{1'b1, 1'b0, 16'h0011, 16'h0000, 16'hBEEF};
    tab[3] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'h1111};
    tab[4] = '{1'b1, 1'b0, 16'h0012, 16'h0000, 16'h3333};
    tab[5] = '{1'b1, 1'b1, 16'h0012, 16'h00AA, 16'h0000};
    tab[6] = '{1'b1, 1'b0, 16'h0012, 16'h0000, 16'h00AA};
    tab[7] = '{1'b1, 1'b0, 16'h0011, 16'h0000, 16'hBEEF};
    tab[8] = '{1'b1, 1'b0, 16'h0024, 16'h0000, 16'h1234};
    tab[9] = '{1'b1, 1'b0, 16'h0025, 16'h0000, 16'h7777};
    mem_model[14'h0004] = 64'h4444_3333_2222_1111;
    mem_model[14'h000C] = 64'hDDDD_CCCC_BBBB_AAAA;
    mem_model[14'h0009] = 64'h9999_8888_7777_6666;

    rst_n = 1'b0; cpu_addr = 16'h0000; cpu_rd = 1'b0; cpu_wr = 1'b0;
    cpu_wrData = 16'h0000; flush = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_stall", 64'(cpu_stall), 64'd0);
    chk("rst_mem_rd", 64'(mem_rd), 64'd0);
    chk("rst_mem_wr", 64'(mem_wr), 64'd0);
    chk("rst_flush_done", 64'(flush_done), 64'd0);
    chk("rst_rdata", 64'(cpu_rdData), 64'd0);
    rst_n = 1'b1;

    // Cold load miss: 1 + L_rd(3) stalled cycles
    log_q.delete();
    do_miss(1'b1, 1'b0, 16'h0010, 16'h0000, 4, "cold");
    chk("cold_rdata", 64'(cpu_rdData), 64'h1111);
    chk("cold_txn_count", 64'(log_q.size()), 64'd1);
    chk_txn("cold_fill", 0, 1'b0, 14'h0004, '0, 1'b0);

    // Hits, including a store, produce no memory traffic
    log_q.delete();
    apply_range(0, 5);
    chk("hits_no_traffic", 64'(log_q.size()), 64'd0);

    // Dirty eviction: 1 + L_wr(2) + L_rd(3)
    log_q.delete();
    do_miss(1'b1, 1'b0, 16'h0030, 16'h0000, 6, "evict");
    chk("evict_rdata", 64'(cpu_rdData), 64'hAAAA);
    chk("evict_txn_count", 64'(log_q.size()), 64'd2);
    chk_txn("evict_wb", 0, 1'b1, 14'h0004, 64'h4444_3333_BEEF_1111, 1'b1);
    chk_txn("evict_fill", 1, 1'b0, 14'h000C, '0, 1'b0);

    // Clean victim: fill only, data comes back from the write-back
    log_q.delete();
    do_miss(1'b1, 1'b0, 16'h0010, 16'h0000, 4, "reload");
    chk("reload_rdata", 64'(cpu_rdData), 64'h1111);
    chk("reload_txn_count", 64'(log_q.size()), 64'd1);
    chk_txn("reload_fill", 0, 1'b0, 14'h0004, '0, 1'b0);

    // Store miss allocates then writes; then simultaneous rd+wr stores
    log_q.delete();
    do_miss(1'b0, 1'b1, 16'h0024, 16'h1234, 4, "wmiss");
    chk_txn("wmiss_fill", 0, 1'b0, 14'h0009, '0, 1'b0);
    log_q.delete();
    apply_range(5, 10);
    chk("hits2_no_traffic", 64'(log_q.size()), 64'd0);

    // Flush with two dirty lines (index 1 scanned before index 4)
    log_q.delete();
    @(posedge clk); #1;
    flush = 1'b1;
    n = 0; stall_ok = 1'b1;
    @(negedge clk);
    while (!flush_done && n < 300) begin
      n++;
      if (n >= 2 && !cpu_stall) stall_ok = 1'b0;
      @(negedge clk);
    end
    chk("flush_done_reached", 64'(n < 300), 64'd1);
    chk("flush_stall", 64'(stall_ok), 64'd1);
    chk("flush_txn_count", 64'(log_q.size()), 64'd2);
    chk_txn("flush_wb0", 0, 1'b1, 14'h0009, 64'h9999_8888_7777_1234, 1'b1);
    chk_txn("flush_wb1", 1, 1'b1, 14'h0004, 64'h4444_00AA_BEEF_1111, 1'b1);
    @(negedge clk);
    chk("flush_done_held", 64'(flush_done), 64'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    repeat (2) @(negedge clk);
    chk("flush_done_drop", 64'(flush_done), 64'd0);
    chk("flush_exit_stall", 64'(cpu_stall), 64'd0);

    // Second flush: nothing dirty, no writes
    log_q.delete();
    @(posedge clk); #1;
    flush = 1'b1;
    n = 0;
    @(negedge clk);
    while (!flush_done && n < 300) begin
      n++;
      @(negedge clk);
    end
    chk("flush2_done_reached", 64'(n < 300), 64'd1);
    chk("flush2_txn_count", 64'(log_q.size()), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in the middle of ALLOC
    lat_rd = 10;
    @(posedge clk); #1;
    cpu_rd = 1'b1; cpu_addr = 16'h0050;
    n = 0;
    @(negedge clk);
    while (!mem_rd && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("rst_mid_alloc_reached", 64'(mem_rd), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_mem_rd", 64'(mem_rd), 64'd0);
    chk("rst_mid_mem_wr", 64'(mem_wr), 64'd0);
    chk("rst_mid_stall", 64'(cpu_stall), 64'd0);
    cpu_rd = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    lat_rd = 3;
    log_q.delete();
    do_miss(1'b1, 1'b0, 16'h0012, 16'h0000, 4, "post_rst");
    chk("post_rst_rdata", 64'(cpu_rdData), 64'h00AA);
    chk_txn("post_rst_fill", 0, 1'b0, 14'h0004, '0, 1'b0);
    @(posedge clk); #1;
    cpu_rd = 1'b0;

    chk("no_rd_wr_overlap", 64'(overlap_seen), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
